dino_game_ctrl: RTL and testbench
=================================

Name: dino_game_ctrl

Overview:
- Central game sequencer for the dinosaur runner; owns game state (idle/run/over), jump trajectory and score.
- Sits between the raw inputs (fresh frame strobe, jump button, START, collision flag) and the sprite/pixel renderers.
- Drives game_status and a registered jump height that the dinosaur renderer subtracts from its baseline row.
- Replaces per-renderer frame-domain logic with a single CLK-domain controller.

Parameters:
- JUMP_FRAMES, 60, jump duration in frames; also the parabola coefficient.
- HEIGHT_DIV, 6, divisor applied to the parabola.
- SCORE_DIV, 6, running frames per score point.
- SCORE_MAX, 9999, saturation value of score.

Ports:
- CLK  in  1  system pixel clock
- RESET  in  1  asynchronous, active-low reset
- fresh  in  1  frame strobe; a frame boundary is its falling edge
- button_jump  in  1  jump button level, asynchronous
- START  in  1  start/restart button level, asynchronous
- collide  in  1  collision flag from the obstacle renderer, CLK domain
- game_status  out  1  1 = running, 0 = idle or over
- game_over  out  1  1 only in OVER
- jumping  out  1  jump in progress
- jump_time  out  12  frame index within the current jump
- height  out  12  dinosaur lift in rows
- score  out  14  binary score
- frame_tick  out  1  one-CLK pulse per frame boundary

Behaviour:
- Reset (RESET=0, async): state=IDLE; every output and internal register is 0.
- Input conditioning: fresh, button_jump and START each pass through a 2-FF synchronizer and edge detector.
  - frame_tick fires on the synced falling edge of fresh.
  - jump_evt fires on the rising edge of button_jump; start_evt fires on the rising edge of START.
  - Latency from pin to pulse is 3 CLK.
- collide is already in the CLK domain and is not synchronized.
- Sticky flags:
  - hit_f sets on any CLK cycle with collide=1 while in RUN.
  - jump_req sets on jump_evt while in RUN.
  - Both flags clear on every frame_tick and on every entry into RUN.
- States (2-bit encoding):
  - IDLE.
  - RUN.
  - OVER.
- Transitions:
  - IDLE, start_evt -> RUN. On entry clear jump_time, jumping, score and the frame counter.
  - RUN, frame_tick with hit_f=1 (or collide=1 that same cycle) -> OVER. Jump and score registers are frozen, not updated.
  - OVER, start_evt -> RUN, with the same clears as from IDLE.
  - start_evt in RUN is ignored. frame_tick in IDLE or OVER changes nothing.
- Jump update, on frame_tick in RUN with no hit:
  - If jumping and jump_time == JUMP_FRAMES: jump_time=0, jumping=0.
  - If jumping otherwise: jump_time += 1.
  - If not jumping and jump_req: jumping=1, jump_time=1.
  - A jump_req while already jumping is discarded; there is no queued re-jump.
- Height:
  - height = (jump_time*JUMP_FRAMES - jump_time^2) / HEIGHT_DIV.
  - Use 24-bit intermediate arithmetic, truncate toward zero, register the result.
  - Valid 1 CLK after jump_time changes.
  - Peak is 150 at t=30; the value is 0 at t=0 and t=60.
- Score:
  - A frame counter increments on each non-hit RUN frame_tick.
  - When the counter reaches SCORE_DIV-1, it wraps to 0 and score += 1.
  - score saturates at SCORE_MAX. It holds in OVER and clears on restart.
- Output decode:
  - game_status = (state==RUN).
  - game_over = (state==OVER).
  - Both are registered and update the cycle after the transition.
- Simultaneous events:
  - hit_f and jump_req in the same frame: OVER wins and no jump starts.
  - start_evt on the same cycle as frame_tick in OVER: enter RUN; that frame does not update jump or score.
- Reset mid-jump or mid-game: immediate return to the reset values above.

Decomposition:
- Package dino_pkg holds:
  - state typedef (IDLE=0, RUN=1, OVER=2);
  - JUMP_FRAMES, HEIGHT_DIV and the baseline row 402 for the renderers;
  - score width.
- One sub-module, sync_edge: 2-FF synchronizer plus rise/fall pulse outputs. It is instantiated 3 times (fresh, button_jump, START).

Test Plan:
- Reset then START pulse -> game_status=1 within 4 CLK; jump_time=0, score=0, height=0.
- Jump press in RUN, then 61 frames -> jump_time steps 1..60 then 0; height=150 at t=30, 0 at t=60; jumping falls at the 61st frame.
- Hold button_jump high across a whole jump -> exactly one jump; no retrigger after landing until a new rising edge.
- 12 running frames -> score=2; collide pulse mid-frame -> next frame_tick gives game_over=1, and score and height freeze.
- Collide and jump press in the same frame -> OVER, jumping stays 0; START in OVER -> RUN with score=0, jump_time=0.
- Assert RESET=0 at jump_time=25, score=40 -> all outputs 0 asynchronously; state IDLE; START needed to resume.

Source files
------------

// File: rtl/dino_pkg.sv
// dino_pkg: shared game state type, timing constants and renderer baseline.
package dino_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, OVER = 2'd2} state_e;
  localparam int DINO_JUMP_FRAMES = 60;
  localparam int DINO_HEIGHT_DIV  = 6;
  localparam int DINO_SCORE_DIV   = 6;
  localparam int DINO_SCORE_MAX   = 9999;
  localparam int DINO_BASE_ROW    = 402;
  localparam int SCORE_W          = 14;
  localparam int JT_W             = 12;
endpackage

// File: rtl/sync_edge.sv
// sync_edge: 2-FF synchronizer with registered rise/fall pulses (3 CLK pin-to-pulse).
module sync_edge (
  input  logic CLK,
  input  logic RESET,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);
  logic [2:0] s_q;
  logic       rise_q, fall_q;
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      s_q    <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s_q    <= {s_q[1:0], d_i};
      rise_q <= s_q[1] & ~s_q[2];
      fall_q <= ~s_q[1] & s_q[2];
    end
  end
  assign rise_o = rise_q;
  assign fall_o = fall_q;
endmodule

// File: rtl/dino_game_ctrl.sv
// dino_game_ctrl: game state sequencer owning jump trajectory, height and score.
module dino_game_ctrl
  import dino_pkg::*;
#(
  parameter int JUMP_FRAMES = DINO_JUMP_FRAMES,
  parameter int HEIGHT_DIV  = DINO_HEIGHT_DIV,
  parameter int SCORE_DIV   = DINO_SCORE_DIV,
  parameter int SCORE_MAX   = DINO_SCORE_MAX
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               fresh,
  input  logic               button_jump,
  input  logic               START,
  input  logic               collide,
  output logic               game_status,
  output logic               game_over,
  output logic               jumping,
  output logic [JT_W-1:0]    jump_time,
  output logic [JT_W-1:0]    height,
  output logic [SCORE_W-1:0] score,
  output logic               frame_tick
);
  state_e             state_q, state_d;
  logic [JT_W-1:0]    jt_q, jt_d, height_q, height_d, fc_q, fc_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               jmp_q, jmp_d, hit_q, hit_d, jreq_q, jreq_d;
  logic               status_q, over_q;
  logic               tick, jump_evt, start_evt, hit, land, wrap;
  logic [2:0]         unused_ev;
  logic [23:0]        arc;
  sync_edge u_fresh (.CLK(CLK), .RESET(RESET), .d_i(fresh),       .rise_o(unused_ev[0]), .fall_o(tick));
  sync_edge u_jump  (.CLK(CLK), .RESET(RESET), .d_i(button_jump), .rise_o(jump_evt),     .fall_o(unused_ev[1]));
  sync_edge u_start (.CLK(CLK), .RESET(RESET), .d_i(START),       .rise_o(start_evt),    .fall_o(unused_ev[2]));
  assign hit  = hit_q | collide;
  assign land = jt_q == JT_W'(JUMP_FRAMES);
  assign wrap = fc_q == JT_W'(SCORE_DIV - 1);
  assign arc  = 24'(jt_q) * 24'(JUMP_FRAMES) - 24'(jt_q) * 24'(jt_q);
  assign height_d = JT_W'(arc / 24'(HEIGHT_DIV));
  always_comb begin
    state_d = state_q;
    jt_d    = jt_q;
    jmp_d   = jmp_q;
    score_d = score_q;
    fc_d    = fc_q;
    hit_d   = hit_q;
    jreq_d  = jreq_q;
    if (state_q != RUN && start_evt) begin
      state_d = RUN;
      jt_d    = '0;
      jmp_d   = 1'b0;
      score_d = '0;
      fc_d    = '0;
      hit_d   = 1'b0;
      jreq_d  = 1'b0;
    end else if (state_q == RUN && tick) begin
      hit_d  = 1'b0;
      jreq_d = 1'b0;
      if (hit) begin
        state_d = OVER;
      end else begin
        // a press during a jump is dropped: jreq only matters when grounded
        jt_d    = jmp_q ? (land ? '0 : jt_q + 1'b1) : (jreq_q ? JT_W'(1) : jt_q);
        jmp_d   = jmp_q ? ~land : jreq_q;
        fc_d    = wrap ? '0 : fc_q + 1'b1;
        score_d = (wrap && score_q != SCORE_W'(SCORE_MAX)) ? score_q + 1'b1 : score_q;
      end
    end else if (state_q == RUN) begin
      hit_d  = hit_q | collide;
      jreq_d = jreq_q | jump_evt;
    end
  end
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= IDLE;
      jt_q     <= '0;
      jmp_q    <= 1'b0;
      score_q  <= '0;
      fc_q     <= '0;
      hit_q    <= 1'b0;
      jreq_q   <= 1'b0;
      height_q <= '0;
      status_q <= 1'b0;
      over_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      jt_q     <= jt_d;
      jmp_q    <= jmp_d;
      score_q  <= score_d;
      fc_q     <= fc_d;
      hit_q    <= hit_d;
      jreq_q   <= jreq_d;
      height_q <= height_d;
      status_q <= state_d == RUN;
      over_q   <= state_d == OVER;
    end
  end
  assign game_status = status_q;
  assign game_over   = over_q;
  assign jumping     = jmp_q;
  assign jump_time   = jt_q;
  assign height      = height_q;
  assign score       = score_q;
  assign frame_tick  = tick;
endmodule

// File: tb/tb_dino_game_ctrl.sv
// tb_dino_game_ctrl: frame-level randomized checks against a rule-based game model.
module tb_dino_game_ctrl;
  logic        CLK = 1'b0, RESET = 1'b0, fresh = 1'b0, button_jump = 1'b0, START = 1'b0, collide = 1'b0;
  logic        game_status, game_over, jumping, frame_tick;
  logic [11:0] jump_time, height;
  logic [13:0] score;
  int tests = 0, fails = 0, ticks = 0, frames = 0;
  int m_state = 0, m_jt = 0, m_jmp = 0, m_runf = 0, m_jreq = 0, m_hit = 0;
  logic [40:0] snap;

  dino_game_ctrl dut (
    .CLK(CLK), .RESET(RESET), .fresh(fresh), .button_jump(button_jump), .START(START),
    .collide(collide), .game_status(game_status), .game_over(game_over), .jumping(jumping),
    .jump_time(jump_time), .height(height), .score(score), .frame_tick(frame_tick)
  );

  always #5 CLK = ~CLK;
  always @(negedge CLK) if (frame_tick) ticks++;

  function automatic int m_height(int t);
    return (t * 60 - t * t) / 6;
  endfunction

  function automatic logic [40:0] exp_vec();
    int s;
    s = (m_runf / 6 > 9999) ? 9999 : m_runf / 6;
    return {m_state == 1, m_state == 2, m_jmp != 0, 12'(m_jt), 12'(m_height(m_jt)), 14'(s)};
  endfunction

  function automatic logic [40:0] dut_vec();
    return {game_status, game_over, jumping, jump_time, height, score};
  endfunction

  task automatic m_reset();
    m_state = 0; m_jt = 0; m_jmp = 0; m_runf = 0; m_jreq = 0; m_hit = 0;
  endtask

  task automatic m_start();
    if (m_state != 1) begin
      m_state = 1; m_jt = 0; m_jmp = 0; m_runf = 0; m_jreq = 0; m_hit = 0;
    end
  endtask

  task automatic m_frame();
    if (m_state == 1) begin
      if (m_hit != 0) m_state = 2;
      else begin
        if (m_jmp != 0) begin
          if (m_jt == 60) begin m_jt = 0; m_jmp = 0; end
          else m_jt++;
        end else if (m_jreq != 0) begin
          m_jmp = 1; m_jt = 1;
        end
        m_runf++;
      end
    end
    m_jreq = 0; m_hit = 0;
  endtask

  task automatic do_frame();
    @(negedge CLK) fresh = 1'b1;
    repeat (6) @(negedge CLK);
    fresh = 1'b0;
    repeat (7) @(negedge CLK);
    frames++;
    m_frame();
  endtask

  task automatic press_jump(input bit hold);
    @(negedge CLK) button_jump = 1'b1;
    repeat (6) @(negedge CLK);
    if (!hold) button_jump = 1'b0;
    repeat (4) @(negedge CLK);
    if (m_state == 1) m_jreq = 1;
  endtask

  task automatic pulse_collide();
    @(negedge CLK) collide = 1'b1;
    @(negedge CLK) collide = 1'b0;
    repeat (2) @(negedge CLK);
    if (m_state == 1) m_hit = 1;
  endtask

  task automatic pulse_start();
    @(negedge CLK) START = 1'b1;
    repeat (8) @(negedge CLK);
    START = 1'b0;
    repeat (4) @(negedge CLK);
    m_start();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLK);
    tests++;
    if ({dut_vec(), frame_tick} !== 42'd0) begin
      fails++; $display("FAIL reset_hold: got %h want 0", {dut_vec(), frame_tick});
    end
    RESET = 1'b1;
    ticks = 0; frames = 0;
    do_frame();
    tests++;
    if (dut_vec() !== exp_vec()) begin
      fails++; $display("FAIL idle_frame: got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_start();
    @(negedge CLK) START = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    tests++;
    if (game_status !== 1'b0) begin
      fails++; $display("FAIL start_early: got %b want 0", game_status);
    end
    @(posedge CLK);
    #1;
    tests++;
    if (game_status !== 1'b1) begin
      fails++; $display("FAIL start_latency: got %b want 1", game_status);
    end
    repeat (6) @(negedge CLK);
    START = 1'b0;
    repeat (2) @(negedge CLK);
    m_start();
    tests++;
    if (dut_vec() !== exp_vec()) begin
      fails++; $display("FAIL start_state: got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_jump();
    press_jump(1'b0);
    for (int f = 1; f <= 61; f++) begin
      do_frame();
      tests++;
      if (dut_vec() !== exp_vec()) begin
        fails++; $display("FAIL jump_f%0d: got %h want %h", f, dut_vec(), exp_vec());
      end
      if (f == 30) begin
        tests++;
        if (height !== 12'd150 || jump_time !== 12'd30) begin
          fails++; $display("FAIL jump_peak: got h=%0d t=%0d want h=150 t=30", height, jump_time);
        end
      end
      if (f == 60) begin
        tests++;
        if (height !== 12'd0 || jump_time !== 12'd60 || jumping !== 1'b1) begin
          fails++; $display("FAIL jump_top_end: got h=%0d t=%0d j=%b want 0 60 1", height, jump_time, jumping);
        end
      end
    end
    tests++;
    if (jumping !== 1'b0 || jump_time !== 12'd0) begin
      fails++; $display("FAIL jump_land: got j=%b t=%0d want 0 0", jumping, jump_time);
    end
    tests++;
    if (ticks !== frames) begin
      fails++; $display("FAIL tick_count: got %0d want %0d", ticks, frames);
    end
  endtask

  task automatic test_hold();
    press_jump(1'b1);
    for (int f = 1; f <= 70; f++) begin
      do_frame();
      tests++;
      if (dut_vec() !== exp_vec()) begin
        fails++; $display("FAIL hold_f%0d: got %h want %h", f, dut_vec(), exp_vec());
      end
    end
    tests++;
    if (jumping !== 1'b0 || jump_time !== 12'd0) begin
      fails++; $display("FAIL hold_retrigger: got j=%b t=%0d want 0 0", jumping, jump_time);
    end
    @(negedge CLK) button_jump = 1'b0;
    repeat (6) @(negedge CLK);
  endtask

  task automatic test_random();
    for (int f = 1; f <= 60; f++) begin
      if ($urandom_range(0, 3) == 0) press_jump(1'b0);
      do_frame();
      tests++;
      if (dut_vec() !== exp_vec()) begin
        fails++; $display("FAIL rand_f%0d: got %h want %h", f, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_score();
    pulse_collide();
    do_frame();
    tests++;
    if (game_over !== 1'b1 || dut_vec() !== exp_vec()) begin
      fails++; $display("FAIL over_entry: got %h want %h", dut_vec(), exp_vec());
    end
    pulse_start();
    for (int f = 0; f < 12; f++) do_frame();
    tests++;
    if (score !== 14'd2 || dut_vec() !== exp_vec()) begin
      fails++; $display("FAIL score12: got %h want %h", dut_vec(), exp_vec());
    end
    press_jump(1'b0);
    repeat (1 + $urandom_range(0, 8)) do_frame();
    pulse_collide();
    do_frame();
    snap = exp_vec();
    tests++;
    if (game_over !== 1'b1 || dut_vec() !== snap) begin
      fails++; $display("FAIL over_mid_jump: got %h want %h", dut_vec(), snap);
    end
    repeat (3) do_frame();
    tests++;
    if (dut_vec() !== snap) begin
      fails++; $display("FAIL over_frozen: got %h want %h", dut_vec(), snap);
    end
  endtask

  task automatic test_back_to_back();
    pulse_start();
    press_jump(1'b0);
    pulse_collide();
    do_frame();
    tests++;
    if (game_over !== 1'b1 || jumping !== 1'b0 || dut_vec() !== exp_vec()) begin
      fails++; $display("FAIL hit_and_jump: got %h want %h", dut_vec(), exp_vec());
    end
    @(negedge CLK) fresh = 1'b1;
    repeat (6) @(negedge CLK);
    fresh = 1'b0;
    START = 1'b1;
    repeat (8) @(negedge CLK);
    START = 1'b0;
    repeat (4) @(negedge CLK);
    frames++;
    m_start();
    tests++;
    if (dut_vec() !== exp_vec() || score !== 14'd0 || jump_time !== 12'd0) begin
      fails++; $display("FAIL start_on_tick: got %h want %h", dut_vec(), exp_vec());
    end
    repeat (5) do_frame();
    tests++;
    if (score !== 14'd0 || dut_vec() !== exp_vec()) begin
      fails++; $display("FAIL start_tick_uncounted: got %h want %h", dut_vec(), exp_vec());
    end
    tests++;
    if (ticks !== frames) begin
      fails++; $display("FAIL tick_count2: got %0d want %0d", ticks, frames);
    end
  endtask

  task automatic test_reset_mid();
    pulse_collide();
    do_frame();
    pulse_start();
    repeat (215) do_frame();
    press_jump(1'b0);
    repeat (25) do_frame();
    tests++;
    if (score !== 14'd40 || jump_time !== 12'd25 || dut_vec() !== exp_vec()) begin
      fails++; $display("FAIL pre_reset: got %h want %h", dut_vec(), exp_vec());
    end
    @(posedge CLK);
    #2 RESET = 1'b0;
    #1;
    m_reset();
    tests++;
    if ({dut_vec(), frame_tick} !== 42'd0) begin
      fails++; $display("FAIL async_reset: got %h want 0", {dut_vec(), frame_tick});
    end
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    press_jump(1'b0);
    do_frame();
    tests++;
    if (dut_vec() !== 41'd0) begin
      fails++; $display("FAIL idle_after_reset: got %h want 0", dut_vec());
    end
    pulse_start();
    tests++;
    if (game_status !== 1'b1 || dut_vec() !== exp_vec()) begin
      fails++; $display("FAIL resume: got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_jump();
    test_hold();
    test_random();
    test_score();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
